// File: rtl/wb8_mailbox_slave.sv
// Wishbone classic 8-bit slave exposing a bidirectional byte mailbox:
// CPU writes feed a downstream FIFO, a local producer feeds an upstream FIFO.
module wb8_mailbox_slave #(
    parameter int         DEPTH       = 4,
    parameter logic [7:0] BASE_ADDR   = 8'h70,
    parameter int         WAIT_STATES = 0
) (
    input  logic       wb_clk_i,
    input  logic       wb_rstn_i,
    input  logic       wb_cyc_i,
    input  logic       wb_stb_i,
    input  logic       wb_we_i,
    input  logic [7:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    output logic       irq,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready
);

    localparam int            PW        = $clog2(DEPTH);
    localparam int            CW        = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [1:0]    LAST_WAIT = 2'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} bus_state_t;

    bus_state_t    state;
    logic [1:0]    wait_cnt;
    logic          enter_ack;
    logic          sel;

    logic [1:0]    acc_off;
    logic          acc_we;
    logic [7:0]    acc_dat;
    logic          acc_empty;

    logic [7:0]    dn_mem [DEPTH];
    logic [PW-1:0] dn_wr, dn_rd;
    logic [CW-1:0] dn_cnt;
    logic [7:0]    up_mem [DEPTH];
    logic [PW-1:0] up_wr, up_rd;
    logic [CW-1:0] up_cnt;

    logic          ovf, unf, en_rx, en_space;
    logic          dn_full, up_full, up_empty;
    logic          acc_done, cpu_wr_data, cpu_rd_data, flush;
    logic          dn_push, dn_pop, up_push, up_pop;
    logic [7:0]    rd_mux;

    assign sel         = wb_cyc_i & wb_stb_i & (wb_adr_i[7:2] == BASE_ADDR[7:2]);
    assign dn_full     = (dn_cnt == FULL_CNT);
    assign up_full     = (up_cnt == FULL_CNT);
    assign up_empty    = (up_cnt == '0);

    assign rx_valid    = (dn_cnt != '0);
    assign rx_data     = dn_mem[dn_rd];
    assign tx_ready    = ~up_full;

    // All register side effects are committed on the edge that closes ACK.
    assign acc_done    = (state == S_ACK);
    assign cpu_wr_data = acc_done & acc_we & (acc_off == 2'd0);
    assign cpu_rd_data = acc_done & ~acc_we & (acc_off == 2'd0);
    assign flush       = acc_done & acc_we & (acc_off == 2'd2) & acc_dat[7];

    assign dn_push     = cpu_wr_data & ~dn_full;
    assign dn_pop      = rx_valid & rx_ready;
    assign up_push     = tx_valid & tx_ready;
    assign up_pop      = cpu_rd_data & ~acc_empty;

    always_comb begin
        rd_mux = 8'h00;
        case (wb_adr_i[1:0])
            2'd0:    rd_mux = up_empty ? 8'h00 : up_mem[up_rd];
            2'd1:    rd_mux = {4'(up_cnt), unf, ovf, dn_full, ~up_empty};
            2'd2:    rd_mux = {6'd0, en_space, en_rx};
            default: rd_mux = 8'h00;
        endcase
    end

    always_comb begin
        enter_ack = 1'b0;
        case (state)
            S_IDLE:  enter_ack = sel && (WAIT_STATES == 0);
            S_WAIT:  enter_ack = wb_cyc_i && wb_stb_i && (wait_cnt == LAST_WAIT);
            default: enter_ack = 1'b0;
        endcase
    end

    // Bus FSM; the access is latched on entry to ACK so read data and
    // the underflow decision both reflect the same FIFO snapshot.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state     <= S_IDLE;
            wait_cnt  <= 2'd0;
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= 8'h00;
            acc_off   <= 2'd0;
            acc_we    <= 1'b0;
            acc_dat   <= 8'h00;
            acc_empty <= 1'b0;
        end else begin
            wb_ack_o <= enter_ack;
            wb_dat_o <= 8'h00;
            if (enter_ack) begin
                wb_dat_o  <= wb_we_i ? 8'h00 : rd_mux;
                acc_off   <= wb_adr_i[1:0];
                acc_we    <= wb_we_i;
                acc_dat   <= wb_dat_i;
                acc_empty <= up_empty;
            end
            case (state)
                S_IDLE: begin
                    if (sel) begin
                        state    <= (WAIT_STATES == 0) ? S_ACK : S_WAIT;
                        wait_cnt <= 2'd0;
                    end
                end
                S_WAIT: begin
                    if (!(wb_cyc_i && wb_stb_i)) state <= S_IDLE;
                    else if (enter_ack)          state <= S_ACK;
                    else                         wait_cnt <= wait_cnt + 2'd1;
                end
                S_ACK:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (dn_push) dn_mem[dn_wr] <= acc_dat;
        if (up_push) up_mem[up_wr] <= tx_data;
    end

    // Flush wins over any local push/pop in the same cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            dn_wr  <= '0;
            dn_rd  <= '0;
            dn_cnt <= '0;
            up_wr  <= '0;
            up_rd  <= '0;
            up_cnt <= '0;
        end else if (flush) begin
            dn_wr  <= '0;
            dn_rd  <= '0;
            dn_cnt <= '0;
            up_wr  <= '0;
            up_rd  <= '0;
            up_cnt <= '0;
        end else begin
            if (dn_push) dn_wr <= dn_wr + 1'b1;
            if (dn_pop)  dn_rd <= dn_rd + 1'b1;
            if (up_push) up_wr <= up_wr + 1'b1;
            if (up_pop)  up_rd <= up_rd + 1'b1;
            dn_cnt <= dn_cnt + CW'(dn_push) - CW'(dn_pop);
            up_cnt <= up_cnt + CW'(up_push) - CW'(up_pop);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            ovf      <= 1'b0;
            unf      <= 1'b0;
            en_rx    <= 1'b0;
            en_space <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (acc_done && acc_we && (acc_off == 2'd2)) begin
                en_rx    <= acc_dat[0];
                en_space <= acc_dat[1];
            end
            if (acc_done && acc_we && (acc_off == 2'd3)) begin
                if (acc_dat[2]) ovf <= 1'b0;
                if (acc_dat[3]) unf <= 1'b0;
            end
            if (cpu_wr_data && dn_full)   ovf <= 1'b1;
            if (cpu_rd_data && acc_empty) unf <= 1'b1;
            irq <= (en_rx & ~up_empty) | (en_space & ~dn_full);
        end
    end

endmodule

// File: tb/tb_wb8_mailbox_slave.sv
// Bench for wb8_mailbox_slave: a queue-based mailbox model checks the
// zero-wait instance every cycle; a two-wait instance shares the bus.
module tb_wb8_mailbox_slave;

    localparam int         DEPTH = 4;
    localparam int         M_WS  = 0;
    localparam logic [7:0] BASE0 = 8'h70;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [7:0] wb_adr = 8'h00, wb_dat = 8'h00;
    logic       rx_ready = 1'b0, tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;

    logic [7:0] dat0, dat1, rx_data0, rx_data1;
    logic       ack0, ack1, irq0, irq1, rx_valid0, rx_valid1, tx_ready0, tx_ready1;
    logic       ack_bus;
    logic [7:0] dat_bus;

    int vec_cnt = 0;
    int err_cnt = 0;
    bit chk_on  = 1'b0;

    always #5 clk = ~clk;

    assign ack_bus = ack0 | ack1;
    assign dat_bus = dat0 | dat1;

    wb8_mailbox_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE0), .WAIT_STATES(M_WS)) dut0 (
        .wb_clk_i(clk), .wb_rstn_i(rstn), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
        .wb_we_i(wb_we), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(dat0),
        .wb_ack_o(ack0), .irq(irq0), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready0)
    );

    wb8_mailbox_slave #(.DEPTH(DEPTH), .BASE_ADDR(8'h74), .WAIT_STATES(2)) dut1 (
        .wb_clk_i(clk), .wb_rstn_i(rstn), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
        .wb_we_i(wb_we), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(dat1),
        .wb_ack_o(ack1), .irq(irq1), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready1)
    );

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Mailbox model for dut0: two byte queues plus status bits, advanced
    // once per clock edge from the stimulus the bench itself drives.
    logic [7:0] m_dn[$];
    logic [7:0] m_up[$];
    bit         m_ovf, m_unf, m_en_rx, m_en_space, m_irq, m_ack, m_pend, a_we;
    bit         m_dn_full, m_up_ne, m_rx_pop, m_tx_push, m_flush;
    logic [7:0] m_dat = 8'h00, a_adr = 8'h00, a_dat = 8'h00, m_pre_rd = 8'h00;
    int         edge_no = 0, target_edge = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_dn.delete();
            m_up.delete();
            m_ovf = 0; m_unf = 0; m_en_rx = 0; m_en_space = 0;
            m_irq = 0; m_ack = 0; m_pend = 0; m_dat = 8'h00;
        end else begin
            m_dn_full = (m_dn.size() == DEPTH);
            m_up_ne   = (m_up.size() != 0);
            m_rx_pop  = (m_dn.size() != 0) && rx_ready;
            m_tx_push = tx_valid && (m_up.size() < DEPTH);
            case (wb_adr[1:0])
                2'd0:    m_pre_rd = m_up_ne ? m_up[0] : 8'h00;
                2'd1:    m_pre_rd = {4'(m_up.size()), m_unf, m_ovf, m_dn_full, m_up_ne};
                2'd2:    m_pre_rd = {6'd0, m_en_space, m_en_rx};
                default: m_pre_rd = 8'h00;
            endcase
            m_irq = (m_en_rx && m_up_ne) || (m_en_space && !m_dn_full);

            m_flush = m_ack && a_we && (a_adr[1:0] == 2'd2) && a_dat[7];
            if (m_flush) begin
                m_dn.delete();
                m_up.delete();
            end else begin
                if (m_rx_pop) void'(m_dn.pop_front());
                if (m_ack && a_adr[1:0] == 2'd0) begin
                    if (a_we) begin
                        if (m_dn_full) m_ovf = 1;
                        else           m_dn.push_back(a_dat);
                    end else begin
                        if (!m_up_ne) m_unf = 1;
                        else          void'(m_up.pop_front());
                    end
                end
                if (m_tx_push) m_up.push_back(tx_data);
            end
            if (m_ack && a_we && a_adr[1:0] == 2'd2) begin
                m_en_rx    = a_dat[0];
                m_en_space = a_dat[1];
            end
            if (m_ack && a_we && a_adr[1:0] == 2'd3) begin
                if (a_dat[2]) m_ovf = 0;
                if (a_dat[3]) m_unf = 0;
            end

            if (m_ack) begin
                m_ack = 0;
            end else begin
                if (!m_pend && wb_cyc && wb_stb && wb_adr[7:2] == BASE0[7:2]) begin
                    m_pend      = 1;
                    target_edge = edge_no + M_WS;
                end
                if (m_pend) begin
                    if (!(wb_cyc && wb_stb)) begin
                        m_pend = 0;
                    end else if (edge_no == target_edge) begin
                        m_pend = 0;
                        m_ack  = 1;
                        a_adr  = wb_adr;
                        a_we   = wb_we;
                        a_dat  = wb_dat;
                        m_dat  = wb_we ? 8'h00 : m_pre_rd;
                    end
                end
            end
            edge_no++;
        end
    end

    // Every-cycle comparison of dut0 against the model.
    always @(negedge clk) begin
        if (chk_on && rstn) begin
            checkOutput("ack", 8'(ack0), 8'(m_ack));
            if (!m_ack || !a_we) checkOutput("dat_o", dat0, m_ack ? m_dat : 8'h00);
            checkOutput("rx_valid", 8'(rx_valid0), 8'(m_dn.size() != 0));
            if (m_dn.size() != 0) checkOutput("rx_data", rx_data0, m_dn[0]);
            checkOutput("tx_ready", 8'(tx_ready0), 8'(m_up.size() < DEPTH));
            checkOutput("irq", 8'(irq0), 8'(m_irq));
        end
    end

    function automatic logic [7:0] expLat(input logic [7:0] a);
        return (a[7:2] == 6'h1D) ? 8'd3 : 8'd1;
    endfunction

    task automatic applyStimulus(input logic [7:0] a, input logic we_v, input logic [7:0] d,
                                 output logic [7:0] rdata, output int lat);
        bit got;
        got   = 0;
        rdata = 8'h00;
        lat   = -1;
        wb_adr = a; wb_we = we_v; wb_dat = d; wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if (ack_bus) begin
                got   = 1;
                lat   = i;
                rdata = dat_bus;
            end
        end
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        if (!got) checkOutput("ack_timeout", 8'h00, 8'h01);
    endtask

    task automatic busWrite(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] r;
        int lat;
        applyStimulus(a, 1'b1, d, r, lat);
        checkOutput("wr_latency", 8'(lat), expLat(a));
    endtask

    task automatic busRead(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] r;
        int lat;
        applyStimulus(a, 1'b0, 8'h00, r, lat);
        checkOutput(name, r, exp);
        checkOutput("rd_latency", 8'(lat), expLat(a));
    endtask

    task automatic pushTx(input logic [7:0] d);
        tx_data = d; tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    logic [7:0] got_rx [8];
    int         n_rx;
    bit         seen;

    initial begin
        repeat (2) @(posedge clk); #1;
        checkOutput("rst_ack", 8'(ack0), 8'h00);
        checkOutput("rst_dat", dat0, 8'h00);
        checkOutput("rst_irq", 8'(irq0), 8'h00);
        checkOutput("rst_rx_valid", 8'(rx_valid0), 8'h00);
        checkOutput("rst_tx_ready", 8'(tx_ready0), 8'h01);
        rstn = 1'b1; chk_on = 1'b1;
        @(posedge clk); #1;

        // Two-wait instance: abort during WAIT, then a full access.
        pushTx(8'h11);
        busRead("ws_status", 8'h75, 8'h11);
        wb_adr = 8'h74; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ack_bus) seen = 1;
        end
        checkOutput("abort_no_ack", 8'(seen), 8'h00);
        @(posedge clk); #1;
        busRead("abort_no_pop", 8'h75, 8'h11);
        busRead("ws_data", 8'h74, 8'h11);
        busRead("dut0_drain", 8'h70, 8'h11);

        // Downstream delivery.
        busWrite(8'h70, 8'hA5);
        busWrite(8'h70, 8'h3C);
        @(negedge clk);
        checkOutput("rx_valid_held", 8'(rx_valid0), 8'h01);
        checkOutput("rx_head", rx_data0, 8'hA5);
        @(posedge clk); #1;
        rx_ready = 1'b1;
        @(negedge clk);
        checkOutput("rx_first", rx_data0, 8'hA5);
        @(negedge clk);
        checkOutput("rx_second", rx_data0, 8'h3C);
        @(posedge clk); #1;
        rx_ready = 1'b0;
        @(negedge clk);
        checkOutput("rx_drained", 8'(rx_valid0), 8'h00);
        @(posedge clk); #1;

        // Upstream reads and underflow.
        pushTx(8'h11);
        pushTx(8'h22);
        busRead("status_two", 8'h71, 8'h21);
        busRead("up_first", 8'h70, 8'h11);
        busRead("up_second", 8'h70, 8'h22);
        busRead("underflow_data", 8'h70, 8'h00);
        busRead("status_unf", 8'h71, 8'h08);
        busWrite(8'h73, 8'h08);
        busRead("status_unf_clr", 8'h71, 8'h00);

        // Overflow on the fifth write.
        for (int i = 1; i <= 5; i++) busWrite(8'h70, 8'(i));
        busRead("status_ovf", 8'h71, 8'h06);
        rx_ready = 1'b1; n_rx = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rx_valid0) begin
                if (n_rx < 8) got_rx[n_rx] = rx_data0;
                n_rx++;
            end
        end
        @(posedge clk); #1;
        rx_ready = 1'b0;
        checkOutput("ovf_rx_count", 8'(n_rx), 8'd4);
        for (int k = 0; k < 4; k++) checkOutput("ovf_rx_byte", got_rx[k], 8'(k + 1));
        busWrite(8'h73, 8'h04);
        busRead("status_ovf_clr", 8'h71, 8'h00);

        // Interrupt behaviour.
        busWrite(8'h72, 8'h01);
        repeat (2) @(posedge clk); #1;
        checkOutput("irq_idle", 8'(irq0), 8'h00);
        pushTx(8'h5A);
        @(negedge clk);
        checkOutput("irq_not_yet", 8'(irq0), 8'h00);
        @(negedge clk);
        checkOutput("irq_rise", 8'(irq0), 8'h01);
        @(posedge clk); #1;
        busRead("irq_data", 8'h70, 8'h5A);
        @(negedge clk);
        checkOutput("irq_still", 8'(irq0), 8'h01);
        @(negedge clk);
        checkOutput("irq_fall", 8'(irq0), 8'h00);
        @(posedge clk); #1;
        busRead("ctrl_read", 8'h72, 8'h01);
        busWrite(8'h72, 8'h02);
        repeat (2) @(posedge clk); #1;
        checkOutput("irq_space", 8'(irq0), 8'h01);
        busWrite(8'h72, 8'h00);

        // CPU read with a simultaneous local push.
        pushTx(8'h31);
        tx_data = 8'h32; tx_valid = 1'b1;
        busRead("rd_with_push", 8'h70, 8'h31);
        tx_valid = 1'b0;
        busRead("count_after_push", 8'h71, 8'h21);
        busRead("drain_a", 8'h70, 8'h32);
        busRead("drain_b", 8'h70, 8'h32);

        // Flush with a concurrent push; underflow stays sticky.
        busRead("pre_flush_unf", 8'h70, 8'h00);
        busWrite(8'h70, 8'h44);
        busWrite(8'h70, 8'h55);
        pushTx(8'h66);
        tx_data = 8'h77; tx_valid = 1'b1;
        busWrite(8'h72, 8'h80);
        tx_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_rx_valid", 8'(rx_valid0), 8'h00);
        checkOutput("flush_tx_ready", 8'(tx_ready0), 8'h01);
        @(posedge clk); #1;
        busRead("flush_status", 8'h71, 8'h08);
        busRead("flush_ctrl", 8'h72, 8'h00);
        busWrite(8'h73, 8'h08);

        // Reset during a WAIT cycle with data buffered.
        for (int i = 0; i < 3; i++) busWrite(8'h70, 8'(8'hC0 + i));
        for (int i = 0; i < 4; i++) pushTx(8'(8'hD0 + i));
        @(negedge clk);
        checkOutput("pre_rst_rx_valid", 8'(rx_valid0), 8'h01);
        checkOutput("pre_rst_tx_ready", 8'(tx_ready0), 8'h00);
        @(posedge clk); #1;
        wb_adr = 8'h75; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checkOutput("rst_mid_ack", 8'(ack_bus), 8'h00);
        checkOutput("rst_mid_dat", dat_bus, 8'h00);
        checkOutput("rst_mid_rx_valid", 8'(rx_valid0), 8'h00);
        checkOutput("rst_mid_tx_ready", 8'(tx_ready0), 8'h01);
        checkOutput("rst_mid_irq", 8'(irq0), 8'h00);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ack_bus) seen = 1;
        end
        checkOutput("rst_no_ack", 8'(seen), 8'h00);
        @(posedge clk); #1;
        busRead("rst_status0", 8'h71, 8'h00);
        busRead("rst_status1", 8'h75, 8'h00);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/wb8_mailbox_slave.md
# wb8_mailbox_slave

8-bit Wishbone classic slave that answers the SoC's 8-bit Wishbone master, sitting on the same bus as the EFB. It provides a bidirectional byte mailbox. Bytes written by the CPU enter a downstream FIFO that is drained by a local valid/ready consumer. Bytes pushed by a local producer enter an upstream FIFO that the CPU reads. A level interrupt reports data-available and space-available conditions.

## Interface
Parameters:
- DEPTH, 4, entries per FIFO; legal values 2, 4, 8.
- BASE_ADDR, 8'h70, base of a 4-byte register window; bits [1:0] must be 0.
- WAIT_STATES, 0, extra cycles inserted before ack; legal range 0–3.

Ports:
- wb_clk_i  in  1  clock; all logic is on its rising edge.
- wb_rstn_i  in  1  asynchronous reset, active-low.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic cycle, strobe and write-enable.
- wb_adr_i  in  8  byte address.
- wb_dat_i  in  8  write data.
- wb_dat_o  out  8  read data; 0 whenever wb_ack_o is low.
- wb_ack_o  out  1  single-cycle acknowledge.
- irq  out  1  level interrupt, registered.
- rx_data  out  8  head of the downstream FIFO (show-ahead).
- rx_valid  out  1  downstream FIFO non-empty.
- rx_ready  in  1  consumer accepts rx_data.
- tx_data  in  8  byte from the local producer.
- tx_valid  in  1  producer has a byte.
- tx_ready  out  1  upstream FIFO not full.

## Operation
- Address decode: the block is selected when wb_cyc_i & wb_stb_i & (wb_adr_i[7:2] == BASE_ADDR[7:2]). When unselected it never acks and drives wb_dat_o = 0, so the bus can OR it with other slaves.
- Registers, at offset wb_adr_i[1:0]:
  - 0 DATA. A write pushes wb_dat_i into the downstream FIFO. A read pops the upstream FIFO and returns the popped byte.
  - 1 STATUS (read-only). bit0 = upstream non-empty, bit1 = downstream full, bit2 = overflow (sticky), bit3 = underflow (sticky), bits[7:4] = upstream count.
  - 2 CTRL. bit0 = irq_en_rx, bit1 = irq_en_space; bits [6:2] read as 0. bit7 = flush: writing 1 self-clears and always reads 0.
  - 3 CLEAR. Writing 1 to bit2 or bit3 clears the matching sticky bit. Reads return 0.
- Writes to read-only bits are ignored. Every selected access is acked.
- Overflow: a DATA write while the downstream FIFO is full drops the byte, sets overflow and is still acked.
- Underflow: a DATA read while the upstream FIFO is empty returns 8'h00, sets underflow, and leaves the pointers unchanged.
- Local ports:
  - Downstream pop occurs on rx_valid & rx_ready.
  - Upstream push occurs on tx_valid & tx_ready.
- Flush empties both FIFOs in the ack cycle. A local push or pop in that same cycle is discarded. Sticky bits and CTRL enables are unaffected.
- irq is registered from (irq_en_rx & upstream non-empty) | (irq_en_space & !downstream full).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Counts are $clog2(DEPTH)+1 bits, zero-extended into STATUS[7:4].

## Timing
- Bus FSM states: IDLE, WAIT, ACK.
  - IDLE → WAIT when selected and WAIT_STATES > 0; IDLE → ACK when selected and WAIT_STATES = 0.
  - WAIT counts WAIT_STATES cycles, then goes to ACK.
  - ACK lasts exactly 1 cycle, then returns to IDLE.
- Latency: the strobe is sampled at edge N; wb_ack_o is high during cycle N+1+WAIT_STATES.
- Back-to-back accesses always have at least one IDLE cycle between acks.
- Side effects (push, pop, sticky set, CTRL/CLEAR update) happen exactly once, at the edge that ends the ACK cycle. wb_dat_o is registered and valid only during ACK.
- Read data is captured on entry to ACK. FIFO pointers do not move before the ACK edge, so the returned byte is consistent.
- If wb_cyc_i or wb_stb_i drops during WAIT, the FSM returns to IDLE with no ack and no side effect. ACK is not abortable.
- Simultaneous events:
  - A CPU DATA read and a local upstream push in the same cycle both take effect; the count is unchanged.
  - A CPU DATA write and a local downstream pop in the same cycle both take effect.
  - A write to a full downstream FIFO in the same cycle as a local pop is still an overflow (fullness is sampled before the pop).
- Reset (asynchronous, immediate, including mid-transaction):
  - FSM → IDLE.
  - wb_ack_o = 0, wb_dat_o = 0, irq = 0.
  - FIFOs empty, so rx_valid = 0 and tx_ready = 1.
  - CTRL = 0, sticky bits = 0.
  - An access interrupted by reset is never acked.

## Test plan
- Write 8'hA5 then 8'h3C to DATA, with rx_ready held low. Response: rx_valid = 1 and rx_data = A5. Raise rx_ready for 2 cycles: A5 then 3C are delivered, then rx_valid = 0. With WAIT_STATES = 0, each ack arrives exactly one cycle after stb.
- Push 8'h11, 8'h22 via tx. STATUS reads 8'h21. Two DATA reads return 11 then 22. A third DATA read returns 00, and STATUS bit3 = 1. Write CLEAR 8'h08: bit3 clears.
- With DEPTH = 4, make 5 DATA writes and keep rx_ready = 0. STATUS bit1 = 1 and bit2 = 1; the consumer later receives only the first 4 bytes.
- Set CTRL = 8'h01 with the upstream FIFO empty: irq = 0. Push one tx byte: irq goes high 1 cycle later. Read DATA: irq falls one cycle after the ACK edge.
- With WAIT_STATES = 2, drop wb_stb_i after 1 WAIT cycle: no ack and no pop. Repeat the access without dropping: ack at N+3.
- Assert wb_rstn_i low during WAIT with 3 bytes buffered: immediately ack = 0, rx_valid = 0, tx_ready = 1, and STATUS reads 00 after release. Also write CTRL = 8'h80 while tx_valid is pushing: both FIFOs are empty afterwards.
